// File: rtl/z_scan_ctrl.sv
// z_scan_ctrl: steps decoder code V across [FIRST, LAST], holds each code DWELL cycles,
// samples Z and accumulates per-scan statistics (last, sum, max and the code that produced it).
module z_scan_ctrl #(
    parameter int         DWELL = 4,
    parameter logic [3:0] FIRST = 4'd0,
    parameter logic [3:0] LAST  = 4'd15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       step_mode,
    input  logic       step,
    input  logic [2:0] Z,
    output logic [3:0] V,
    output logic       busy,
    output logic       cap_valid,
    output logic [2:0] z_cap,
    output logic [6:0] z_sum,
    output logic [2:0] z_max,
    output logic [3:0] v_at_max,
    output logic       done
);
    typedef enum logic [2:0] {IDLE, SETTLE, CAPTURE, WAIT, DONE} state_t;
    localparam logic [7:0] RELOAD = 8'(DWELL - 1);
    state_t     state;
    logic [7:0] count;
    logic [3:0] v_next;
    // saturate at LAST so the code never wraps
    assign v_next = (V < LAST) ? V + 4'd1 : V;
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            V         <= FIRST;
            count     <= 8'd0;
            busy      <= 1'b0;
            cap_valid <= 1'b0;
            z_cap     <= 3'd0;
            z_sum     <= 7'd0;
            z_max     <= 3'd0;
            v_at_max  <= FIRST;
            done      <= 1'b0;
        end else begin
            cap_valid <= 1'b0;
            done      <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    V        <= FIRST;
                    z_sum    <= 7'd0;
                    z_max    <= 3'd0;
                    v_at_max <= FIRST;
                    count    <= RELOAD;
                    busy     <= 1'b1;
                    state    <= SETTLE;
                end
                SETTLE: begin
                    if (count == 8'd0) state <= CAPTURE;
                    else count <= count - 8'd1;
                end
                CAPTURE: begin
                    z_cap     <= Z;
                    cap_valid <= 1'b1;
                    z_sum     <= z_sum + 7'(Z);
                    // strict compare keeps the earliest code on ties
                    if (Z > z_max) begin
                        z_max    <= Z;
                        v_at_max <= V;
                    end
                    if (V == LAST) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else if (step_mode) begin
                        state <= WAIT;
                    end else begin
                        V     <= v_next;
                        count <= RELOAD;
                        state <= SETTLE;
                    end
                end
                WAIT: if (step || !step_mode) begin
                    V     <= v_next;
                    count <= RELOAD;
                    state <= SETTLE;
                end
                DONE: state <= IDLE;
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/z_scan_ctrl.md
# z_scan_ctrl

Sequencer for the 4-input/3-output combinational decoder stage (V[3:0] -> Z[2:0]). It steps V through a programmable code range, holds each code for a fixed settle time, samples Z, and accumulates per-scan statistics (last value, sum, maximum and the code that produced it). It sits between the board-level control (start/step buttons) and the decoder, replacing the manual code-by-code stimulus used during bring-up.

## Interface

- DWELL, 4, settle cycles each code is held before Z is sampled; legal range 1..255
- FIRST, 4'd0, first code driven in a scan
- LAST, 4'd15, last code driven in a scan; FIRST <= LAST required
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  level; sampled in IDLE only, begins a scan
- step_mode  in  1  1 = pause after each capture until step
- step  in  1  advance to next code when paused (WAIT)
- Z  in  3  decoder output
- V  out  4  decoder input, registered
- busy  out  1  high in SETTLE, CAPTURE, WAIT
- cap_valid  out  1  one-cycle pulse when z_cap updates
- z_cap  out  3  last sampled Z
- z_sum  out  7  sum of Z over current scan (max 16*7 = 112, no overflow)
- z_max  out  3  largest Z sampled this scan
- v_at_max  out  4  code that first produced z_max
- done  out  1  one-cycle pulse at scan completion

## Operation

- States: IDLE, SETTLE, CAPTURE, WAIT, DONE. Dwell counter 8 bits.
- Reset: state IDLE, V=FIRST, z_cap=0, z_sum=0, z_max=0, v_at_max=FIRST, busy=0, cap_valid=0, done=0, counter=0.
- IDLE: start=1 -> V<=FIRST, z_sum<=0, z_max<=0, v_at_max<=FIRST, counter<=DWELL-1, go SETTLE. Otherwise hold all outputs (results of previous scan remain readable).
- SETTLE: counter decrements each cycle; at counter=0 go CAPTURE. V stable throughout.
- CAPTURE (one cycle): z_cap<=Z, cap_valid=1 next cycle, z_sum<=z_sum+Z (zero-extended), if Z > z_max (strict) then z_max<=Z, v_at_max<=V. Then:
  - V==LAST -> DONE.
  - else step_mode=1 -> WAIT.
  - else V<=V+1, counter<=DWELL-1, SETTLE.
- WAIT: step=1 -> V<=V+1, counter<=DWELL-1, SETTLE. step_mode dropping to 0 while in WAIT also advances.
- DONE: done=1 for this cycle, busy=0, go IDLE. V holds LAST.
- V never wraps: increment only when V<LAST.
- Ties on maximum keep the earliest code; z_max=0 with all-zero Z leaves v_at_max=FIRST.
- start ignored outside IDLE; start held high at DONE->IDLE begins a new scan on the next cycle.
- rst has priority over every other input, in any state; mid-scan rst abandons the scan and restores reset values on the next edge.

## Timing

- start sampled at edge 0 -> busy=1 and V=FIRST from edge 0.
- Each code: DWELL SETTLE cycles + 1 CAPTURE cycle = DWELL+1 cycles; Z is sampled ≥ DWELL cycles after V changes.
- Free-run scan of N = LAST-FIRST+1 codes: done=1 in cycle N*(DWELL+1) after start edge (80 for defaults), busy=0 in that cycle.
- cap_valid and updated z_cap/z_sum/z_max visible the cycle after CAPTURE.
- Step mode: each step adds 1 cycle in WAIT minimum; step in other states ignored.
- All outputs registered; no combinational path from inputs to outputs.

## Test plan

- Defaults, bench model Z=popcount(V), start pulse -> 16 cap_valid pulses, z_sum=32, z_max=4, v_at_max=15, done at cycle 80, busy low at done.
- LAST=14, same model -> z_max=3, v_at_max=7 (first tie kept), z_sum=28, done at cycle 75.
- FIRST=LAST=9, DWELL=1 -> single capture z_cap=2, z_sum=2, done at cycle 2, V stays 9.
- step_mode=1, step pulsed every 10 cycles -> V advances only after each step, WAIT holds V, final results identical to scenario 1.
- rst asserted while V=5 in SETTLE -> next cycle state IDLE, V=0, z_sum=0, z_max=0, busy=0, no done pulse; start afterwards gives full scenario-1 result.
- start re-asserted while busy -> ignored, scan completes unchanged; start held high through done -> new scan begins one cycle after done with z_sum cleared.
